// File: rtl/act_skew_feeder_if.sv
// Row-in / skewed-lanes-out bundle between the activation buffer side and the feeder.
interface act_skew_feeder_if #(
  parameter int ACCU_NUM = 5,
  parameter int BW_ACT   = 8
);
  logic                       start;
  logic                       row_valid;
  logic                       row_ready;
  logic [ACCU_NUM*BW_ACT-1:0] row_data;
  logic [ACCU_NUM*BW_ACT-1:0] PE_act_in;
  logic                       act_valid;
  logic                       busy;
  logic                       done;

  modport master (
    output start, row_valid, row_data,
    input  row_ready, PE_act_in, act_valid, busy, done
  );

  modport slave (
    input  start, row_valid, row_data,
    output row_ready, PE_act_in, act_valid, busy, done
  );
endinterface

// File: rtl/act_skew_feeder.sv
// Activation skew feeder: turns a tile of BN_NUM rows into the diagonally
// skewed per-lane stream for the systolic MAC array, plus its advance strobe.

// One lane: a DEPTH-deep register chain that moves only on advance steps.
module act_skew_lane #(
  parameter int DEPTH = 1,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         adv,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  logic [DEPTH-1:0][W-1:0] sr_q, sr_d;

  // Shift one slot per advance step; wiped while the feeder is idle so the
  // array sees zeros between tiles.
  always_comb begin
    sr_d = sr_q;
    if (clr) begin
      sr_d = '0;
    end else if (adv) begin
      sr_d[0] = din;
      for (int j = 1; j < DEPTH; j++) sr_d[j] = sr_q[j-1];
    end
  end

  // Chain registers.
  always_ff @(posedge clk) begin
    if (reset) sr_q <= '0;
    else       sr_q <= sr_d;
  end

  assign dout = sr_q[DEPTH-1];
endmodule

module act_skew_feeder #(
  parameter int ACCU_NUM = 5,
  parameter int BN_NUM   = 10,
  parameter int BW_ACT   = 8
) (
  input  logic               clk,
  input  logic               reset,
  act_skew_feeder_if.slave   bus
);
  localparam int CNT_W = $clog2(BN_NUM + 1);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

  state_t             state_q, state_d;
  // Rows accepted while filling, drain steps taken while draining.
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               act_valid_q, act_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               fill, idle, accept, adv, last;

  logic [ACCU_NUM-1:0][BW_ACT-1:0] lane_in, lane_out;

  // Next-state, step counting and the strobes that get registered with the step.
  always_comb begin
    fill    = (state_q == FILL);
    idle    = (state_q == IDLE);
    accept  = fill && bus.row_valid;
    adv     = accept || (state_q == DRAIN);
    last    = 1'b0;
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = FILL;
          cnt_d   = '0;
        end
      end
      FILL: begin
        if (accept) begin
          if (cnt_q == CNT_W'(BN_NUM - 1)) begin
            cnt_d = '0;
            // A single lane has nothing to drain: the last row is the last step.
            if (ACCU_NUM == 1) begin
              state_d = IDLE;
              last    = 1'b1;
            end else begin
              state_d = DRAIN;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (cnt_q == CNT_W'(ACCU_NUM - 2)) begin
          state_d = IDLE;
          last    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    act_valid_d = adv;
    done_d      = last;
    // busy covers the done cycle, which is already spent in IDLE.
    busy_d      = (state_d != IDLE) || last;
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      act_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      act_valid_q <= act_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Lane k has depth k+1, which produces the k-step diagonal skew; drain
  // steps inject zeros so trailing slots come out padded.
  for (genvar k = 0; k < ACCU_NUM; k++) begin : g_lane
    assign lane_in[k] = fill ? bus.row_data[k*BW_ACT +: BW_ACT] : '0;
    act_skew_lane #(.DEPTH(k + 1), .W(BW_ACT)) u_lane (
      .clk  (clk),
      .reset(reset),
      .adv  (adv),
      .clr  (idle),
      .din  (lane_in[k]),
      .dout (lane_out[k])
    );
  end

  assign bus.PE_act_in = lane_out;
  assign bus.row_ready = fill;
  assign bus.act_valid = act_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule

// File: doc/act_skew_feeder.md
Name: act_skew_feeder

Overview:
- Upstream feeder for the systolic MAC array: accepts one activation tile of BN_NUM rows, each row being ACCU_NUM activations along K.
- Produces the diagonally skewed per-lane stream PE_act_in: lane k is delayed k steps relative to lane 0, and every out-of-range slot is zero-padded.
- Also produces the advance strobe act_valid that drives the array's PE_mac_enable.
- Replaces the software skew loop so that the array can be fed directly from the activation buffer.

Parameters:
ACCU_NUM, 5, number of activation lanes (K per pass); must be >= 1
BN_NUM, 10, rows per tile (N per pass); must be >= ACCU_NUM
BW_ACT, 8, signed activation width

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
start  input  1  begin a tile; honoured only in IDLE
row_valid  input  1  row_data holds a valid row
row_ready  output  1  feeder accepts a row this cycle
row_data  input  ACCU_NUM*BW_ACT  lane k is bits [k*BW_ACT +: BW_ACT]
PE_act_in  output  ACCU_NUM*BW_ACT  skewed lanes to the array (registered), same packing as row_data
act_valid  output  1  one array advance step this cycle (drives PE_mac_enable)
busy  output  1  tile in progress
done  output  1  one-cycle pulse on the final step of a tile

Behaviour:
- Reset:
  - State goes to IDLE and all lane delay registers clear.
  - PE_act_in=0, act_valid=0, busy=0, done=0, row_ready=0 in the cycle after reset is sampled.
  - Reset mid-tile aborts the tile, with no done pulse.
- States: IDLE -> FILL -> DRAIN -> IDLE.
- IDLE:
  - row_ready=0; PE_act_in held at 0.
  - start=1 moves to FILL the next cycle.
  - A row_valid in the same cycle as start is not accepted.
- FILL:
  - row_ready=1.
  - Each accepted row (row_valid & row_ready) advances the pipeline one step and increments row_cnt.
  - A cycle without a row is a stall: nothing shifts, act_valid=0, PE_act_in holds its value.
  - After the BN_NUM-th row is accepted, go to DRAIN; with ACCU_NUM=1, go straight to IDLE.
- DRAIN:
  - row_ready=0.
  - Runs exactly ACCU_NUM-1 cycles; each one is an advance step that injects zeros into lane 0.
  - Then returns to IDLE.
- Skew rule:
  - Lane k is a register chain of depth k+1.
  - An advance step accepted in cycle t appears on PE_act_in in cycle t+1, with act_valid=1.
  - At output step s (1 .. BN_NUM+ACCU_NUM-1): lane k = row[s-1-k].lane[k] if 0 <= s-1-k < BN_NUM, else 0.
  - There are exactly BN_NUM+ACCU_NUM-1 act_valid cycles per tile.
- Values pass through unmodified; there is no arithmetic and no sign change.
- done=1 in the same cycle as output step BN_NUM+ACCU_NUM-1.
  - In the next cycle: busy=0, act_valid=0, PE_act_in=0, and a new start is accepted.
- busy=1 from the cycle after start is accepted through the done cycle inclusive.
- start while busy is ignored.
- row_valid outside FILL is ignored; rows are never dropped or double-counted.

Test Plan:
1. Basic tile, default params. Row r lane k = r*10+k+1, row_valid held high; start at cycle 0.
   - Exactly 14 act_valid cycles.
   - Step 1: lanes = {1,0,0,0,0}.
   - Step 5: lane0..4 = {41,32,23,14,5}.
   - Step 14: lane4 = 95, lanes 0-3 = 0.
   - done on step 14 only.
2. Stall: deassert row_valid for 3 cycles after row 4.
   - act_valid=0 for those 3 cycles and PE_act_in frozen.
   - Step sequence identical to scenario 1; still 14 valid steps.
3. Negative data: all rows = -128 (0x80) in every lane.
   - Step 5: every lane = 0x80.
   - Zero-padded slots read 0, with no sign smear.
4. Reset asserted at step 7.
   - Next cycle: PE_act_in=0, act_valid=0, busy=0, no done.
   - A following start gives a clean 14-step tile matching scenario 1.
5. Boundary events:
   - start asserted during FILL: no effect.
   - start in the cycle after done: back-to-back tile, with row_ready=1 two cycles after done.
   - row_valid held high during DRAIN: no row accepted, row_cnt unchanged.
6. Parameter sweep:
   - ACCU_NUM=1, BN_NUM=4: 4 steps, lane0 = rows 0..3, done on the 4th step.
   - ACCU_NUM=BN_NUM=3: 5 steps, step 3 = {row2.l0, row1.l1, row0.l2}.
